// File: rtl/decode_stage.sv
// Single-entry registered RV32 decode stage with valid/ready handshake,
// flush, illegal-instruction detection and a saturating illegal counter.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int ALU_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [ALU_W-1:0] alu_op,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             jump,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [XLEN-1:0]  imm,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0]        opcode;
  logic [3:0]        dec_alu;
  logic              dec_rw;
  logic              dec_mr;
  logic              dec_mw;
  logic              dec_br;
  logic              dec_jmp;
  logic              dec_illegal;
  logic [31:0]       dec_imm32;
  logic [XLEN-1:0]   dec_imm;
  logic              capture;

  assign opcode   = in_instr[6:0];
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign capture  = in_valid && in_ready;

  // Widening a signed 32-bit value sign-extends it to the datapath width.
  assign dec_imm = XLEN'(signed'(dec_imm32));

  // Combinational decode of the incoming word; unknown encodings leave every field zero.
  always_comb begin
    dec_alu     = 4'b0000;
    dec_rw      = 1'b0;
    dec_mr      = 1'b0;
    dec_mw      = 1'b0;
    dec_br      = 1'b0;
    dec_jmp     = 1'b0;
    dec_illegal = 1'b0;
    dec_imm32   = 32'h0;
    if (in_instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (opcode)
        OP_R: begin
          dec_alu = 4'b0001;
          dec_rw  = 1'b1;
        end
        OP_IMM: begin
          dec_alu   = 4'b0110;
          dec_rw    = 1'b1;
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        OP_LOAD: begin
          dec_alu   = 4'b0010;
          dec_rw    = 1'b1;
          dec_mr    = 1'b1;
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        OP_STORE: begin
          dec_alu   = 4'b0010;
          dec_mw    = 1'b1;
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        OP_BRANCH: begin
          dec_alu   = 4'b0011;
          dec_br    = 1'b1;
          dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
        end
        OP_LUI: begin
          dec_alu   = 4'b0100;
          dec_rw    = 1'b1;
          dec_imm32 = {in_instr[31:12], 12'h000};
        end
        OP_AUIPC: begin
          dec_alu   = 4'b1000;
          dec_rw    = 1'b1;
          dec_imm32 = {in_instr[31:12], 12'h000};
        end
        OP_JAL: begin
          dec_alu   = 4'b0101;
          dec_rw    = 1'b1;
          dec_jmp   = 1'b1;
          dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
        end
        OP_JALR: begin
          dec_alu   = 4'b0111;
          dec_rw    = 1'b1;
          dec_jmp   = 1'b1;
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        default: dec_illegal = 1'b1;
      endcase
    end
    if (in_instr[11:7] == 5'd0) begin
      dec_rw = 1'b0;
    end
  end

  // Pipeline register: flush wins, then capture (which also covers consume+capture), then drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      alu_op      <= '0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      branch      <= 1'b0;
      jump        <= 1'b0;
      rd          <= 5'd0;
      rs1         <= 5'd0;
      rs2         <= 5'd0;
      imm         <= '0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      alu_op    <= ALU_W'(dec_alu);
      reg_write <= dec_rw;
      mem_read  <= dec_mr;
      mem_write <= dec_mw;
      branch    <= dec_br;
      jump      <= dec_jmp;
      rd        <= in_instr[11:7];
      rs1       <= in_instr[19:15];
      rs2       <= in_instr[24:20];
      imm       <= dec_imm;
      illegal   <= dec_illegal;
      if (dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
        illegal_cnt <= illegal_cnt + 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (XLEN=32, CNT_W=2 so saturation is reachable).
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int ALU_W = 4;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [ALU_W-1:0] alu_op;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             branch;
  logic             jump;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [XLEN-1:0]  imm;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  int checks;
  int failures;

  decode_stage #(.XLEN(XLEN), .ALU_W(ALU_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .alu_op(alu_op),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = valid;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence: reset, decode formats, stall, flush, illegal saturation, async reset.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    #2;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_imm", 64'(imm), 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // addi x1, x0, 10
    applyStimulus(1'b1, 32'h00A00093, 32'h100);
    tick();
    checkOutput("addi_valid", 64'(out_valid), 64'd1);
    checkOutput("addi_alu", 64'(alu_op), 64'h6);
    checkOutput("addi_rw", 64'(reg_write), 64'd1);
    checkOutput("addi_rd", 64'(rd), 64'd1);
    checkOutput("addi_imm", 64'(imm), 64'd10);
    checkOutput("addi_pc", 64'(out_pc), 64'h100);
    checkOutput("addi_illegal", 64'(illegal), 64'd0);

    // beq x0, x0, -4 back-to-back
    applyStimulus(1'b1, 32'hFE000EE3, 32'h104);
    tick();
    checkOutput("beq_branch", 64'(branch), 64'd1);
    checkOutput("beq_alu", 64'(alu_op), 64'h3);
    checkOutput("beq_imm", 64'(imm), 64'hFFFFFFFC);
    checkOutput("beq_rw", 64'(reg_write), 64'd0);
    checkOutput("beq_pc", 64'(out_pc), 64'h104);

    // add x0, x1, x2: reg_write suppressed for rd=0
    applyStimulus(1'b1, 32'h00208033, 32'h108);
    tick();
    checkOutput("add_x0_alu", 64'(alu_op), 64'h1);
    checkOutput("add_x0_rw", 64'(reg_write), 64'd0);
    checkOutput("add_rs2", 64'(rs2), 64'd2);

    // lw x3, -4(x1)
    applyStimulus(1'b1, 32'hFFC0A183, 32'h10C);
    tick();
    checkOutput("lw_alu", 64'(alu_op), 64'h2);
    checkOutput("lw_mr", 64'(mem_read), 64'd1);
    checkOutput("lw_rw", 64'(reg_write), 64'd1);
    checkOutput("lw_imm", 64'(imm), 64'hFFFFFFFC);
    checkOutput("lw_rs1", 64'(rs1), 64'd1);

    // sw x2, 8(x1)
    applyStimulus(1'b1, 32'h0020A423, 32'h110);
    tick();
    checkOutput("sw_mw", 64'(mem_write), 64'd1);
    checkOutput("sw_mr", 64'(mem_read), 64'd0);
    checkOutput("sw_imm", 64'(imm), 64'd8);

    // idle cycle drains the stage
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("drain_valid", 64'(out_valid), 64'd0);

    // stall: lui x5, 0x12345 captured, then held 3 cycles with out_ready=0
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h123452B7, 32'h200);
    tick();
    applyStimulus(1'b1, 32'h00000317, 32'h204);
    #1;
    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_alu", 64'(alu_op), 64'h4);
      checkOutput("stall_imm", 64'(imm), 64'h12345000);
      checkOutput("stall_pc", 64'(out_pc), 64'h200);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("auipc_valid", 64'(out_valid), 64'd1);
    checkOutput("auipc_alu", 64'(alu_op), 64'h8);
    checkOutput("auipc_rd", 64'(rd), 64'd6);
    checkOutput("auipc_pc", 64'(out_pc), 64'h204);
    // jal x1, 8 immediately behind it: no bubble
    applyStimulus(1'b1, 32'h008000EF, 32'h208);
    tick();
    checkOutput("jal_valid", 64'(out_valid), 64'd1);
    checkOutput("jal_alu", 64'(alu_op), 64'h5);
    checkOutput("jal_jump", 64'(jump), 64'd1);
    checkOutput("jal_imm", 64'(imm), 64'd8);
    checkOutput("jal_pc", 64'(out_pc), 64'h208);

    // flush with a held bundle and an illegal word offered
    applyStimulus(1'b1, 32'h00A00093, 32'h300);
    tick();
    flush = 1'b1;
    applyStimulus(1'b1, 32'h00000000, 32'h304);
    #1;
    checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_cnt", 64'(illegal_cnt), 64'd0);
    checkOutput("flush_pc_kept", 64'(out_pc), 64'h300);

    // illegal words, counter saturates at 3
    applyStimulus(1'b1, 32'h00000000, 32'h400);
    tick();
    checkOutput("ill0_illegal", 64'(illegal), 64'd1);
    checkOutput("ill0_cnt", 64'(illegal_cnt), 64'd1);
    checkOutput("ill0_alu", 64'(alu_op), 64'd0);
    checkOutput("ill0_rw", 64'(reg_write), 64'd0);
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h404);
    tick();
    checkOutput("ill1_illegal", 64'(illegal), 64'd1);
    checkOutput("ill1_cnt", 64'(illegal_cnt), 64'd2);
    checkOutput("ill1_imm", 64'(imm), 64'd0);
    checkOutput("ill1_rw", 64'(reg_write), 64'd0);
    checkOutput("ill1_jump", 64'(jump), 64'd0);
    checkOutput("ill1_rd", 64'(rd), 64'd31);
    checkOutput("ill1_rs1", 64'(rs1), 64'd31);
    tick();
    checkOutput("ill2_cnt", 64'(illegal_cnt), 64'd3);
    tick();
    checkOutput("ill3_cnt_sat", 64'(illegal_cnt), 64'd3);
    // legal word after illegal ones clears the flag
    applyStimulus(1'b1, 32'h00A00093, 32'h500);
    tick();
    checkOutput("legal_after_ill", 64'(illegal), 64'd0);
    checkOutput("legal_cnt_hold", 64'(illegal_cnt), 64'd3);

    // asynchronous reset between edges
    applyStimulus(1'b0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_cnt", 64'(illegal_cnt), 64'd0);
    checkOutput("arst_pc", 64'(out_pc), 64'd0);
    checkOutput("arst_imm", 64'(imm), 64'd0);
    checkOutput("arst_rd", 64'(rd), 64'd0);
    checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
    #2 rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 32'hFE000EE3, 32'h600);
    tick();
    checkOutput("post_rst_valid", 64'(out_valid), 64'd1);
    checkOutput("post_rst_branch", 64'(branch), 64'd1);
    checkOutput("post_rst_imm", 64'(imm), 64'hFFFFFFFC);
    checkOutput("post_rst_pc", 64'(out_pc), 64'h600);
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
